// File: rtl/reu_pkg.sv
// Shared types for the REU DMA sequencer: transfer-type codes, FSM encoding
// and the default length-counter width.
package reu_pkg;

    localparam int REU_LEN_W = 16;

    typedef enum logic [1:0] {
        XT_STASH  = 2'b00,
        XT_FETCH  = 2'b01,
        XT_SWAP   = 2'b10,
        XT_VERIFY = 2'b11
    } xfer_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_XFER   = 3'd1,
        ST_SWAP_A = 3'd2,
        ST_SWAP_B = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/reu_len_counter.sv
// Loadable transfer-length down-counter. A zero length loads as 2^W, and the
// count parks at 1 so the last byte is flagged rather than wrapping.
module reu_len_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    input  logic         dec,
    output logic         last
);

    logic [W:0] cnt;

    assign last = (cnt == (W+1)'(1));

    always_ff @(negedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? {1'b1, {W{1'b0}}} : {1'b0, len};
        end else if (dec && !last) begin
            cnt <= cnt - (W+1)'(1);
        end
    end

endmodule

// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: drives C64 bus ownership and DRAM strobes for stash,
// fetch, swap and verify transfers. All state moves on the falling edge of PHI2.
module reu_dma_seq
    import reu_pkg::*;
#(
    parameter int LEN_W    = REU_LEN_W,
    parameter int SWAP_CYC = 2
) (
    input  logic             PHI2,
    input  logic             RESET,
    input  logic             Execute,
    input  logic [1:0]       XferType,
    input  logic [LEN_W-1:0] Length,
    input  logic             FixC64,
    input  logic             FixREU,
    input  logic             Autoload,
    input  logic             BA,
    input  logic             Equal,
    output logic             DMA,
    output logic             DMARW,
    output logic             RAMRD,
    output logic             RAMWR,
    output logic             LatchC64,
    output logic             NextCA,
    output logic             NextREUA,
    output logic             DecLen,
    output logic             XferEnd,
    output logic             VerifyErr,
    output logic             RegReset,
    output logic             Busy,
    output state_t           dbg_state
);

    // Handshake: Execute is a one-cycle request honoured only in IDLE; a byte
    // cycle advances only when BA=1, otherwise the bus is held and nothing moves.
    state_t state, nxt;
    xfer_t  type_q;
    logic   fixc_q, fixr_q, auto_q, verr_q;
    logic   active, go, start, byte_done, mismatch, xfer_end, last;

    assign active    = (state == ST_XFER) || (state == ST_SWAP_A) || (state == ST_SWAP_B);
    assign go        = active && BA;
    assign start     = (state == ST_IDLE) && Execute;
    assign byte_done = go && ((state == ST_XFER) || (state == ST_SWAP_B));
    assign mismatch  = go && (state == ST_XFER) && (type_q == XT_VERIFY) && !Equal;
    assign xfer_end  = (byte_done && last) || mismatch;
    assign dbg_state = state;

    reu_len_counter #(.W(LEN_W)) u_len (
        .clk  (PHI2),
        .rst  (RESET),
        .load (start),
        .len  (Length),
        .dec  (byte_done),
        .last (last)
    );

    always_ff @(negedge PHI2) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (Execute) begin
                    nxt = (xfer_t'(XferType) == XT_SWAP) ? ST_SWAP_A : ST_XFER;
                end
            end
            ST_XFER: begin
                if (xfer_end) begin
                    nxt = ST_DONE;
                end
            end
            ST_SWAP_A: begin
                if (go && (SWAP_CYC == 2)) begin
                    nxt = ST_SWAP_B;
                end
            end
            ST_SWAP_B: begin
                if (go) begin
                    nxt = xfer_end ? ST_DONE : ST_SWAP_A;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        DMA       = active;
        Busy      = active;
        DMARW     = 1'b0;
        RAMRD     = 1'b0;
        RAMWR     = 1'b0;
        LatchC64  = 1'b0;
        DecLen    = byte_done;
        NextCA    = byte_done && !fixc_q;
        NextREUA  = byte_done && !fixr_q;
        XferEnd   = xfer_end;
        VerifyErr = verr_q;
        RegReset  = (state == ST_DONE) && auto_q;
        if (active && !BA) begin
            DMARW = 1'b1;
        end else begin
            case (state)
                ST_XFER: begin
                    DMARW = (type_q != XT_FETCH);
                    RAMWR = (type_q == XT_STASH);
                    RAMRD = (type_q == XT_FETCH) || (type_q == XT_VERIFY);
                end
                ST_SWAP_A: begin
                    DMARW    = 1'b1;
                    RAMRD    = 1'b1;
                    LatchC64 = 1'b1;
                end
                ST_SWAP_B: begin
                    RAMWR = 1'b1;
                end
                default: begin
                    DMARW = 1'b0;
                end
            endcase
        end
    end

    always_ff @(negedge PHI2) begin
        if (RESET) begin
            type_q <= XT_STASH;
            fixc_q <= 1'b0;
            fixr_q <= 1'b0;
            auto_q <= 1'b0;
            verr_q <= 1'b0;
        end else if (start) begin
            type_q <= xfer_t'(XferType);
            fixc_q <= FixC64;
            fixr_q <= FixREU;
            auto_q <= Autoload;
            verr_q <= 1'b0;
        end else if (mismatch) begin
            verr_q <= 1'b1;
        end
    end

endmodule
